alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Sequences the wall-clock alarm: an edit FSM sets alarm hour and minute from debounced button pulses, arms the alarm, detects a match against the running time, rings, and handles snooze and dismiss.
- Sits beside the seconds, minutes and hours counters and the 7-segment display path.
- Consumes debounced pressed pulses and the clock's 1 Hz tick.
- Drives the buzzer pin and a display-select flag so the top level shows the alarm time while it is being edited.

Parameters:
- DEF_HOUR, 6, alarm hour loaded at reset (0..23).
- DEF_MIN, 0, alarm minute loaded at reset (0..59).
- RING_SECS, 60, ticks of ringing before auto-dismiss (1..255).
- SNOOZE_MIN, 5, snooze length in minutes (1..60); counter reload = SNOOZE_MIN*60.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- tick_1hz  in  1  single-cycle pulse, once per second.
- up_pulse  in  1  debounced up press, one cycle.
- down_pulse  in  1  debounced down press, one cycle.
- center_pulse  in  1  debounced center press, one cycle.
- cur_hour  in  5  current hour, 0..23.
- cur_min  in  6  current minute, 0..59.
- cur_sec  in  6  current second, 0..59.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- buzzer  out  1  buzzer drive, registered.
- show_alarm  out  1  high in SET_HOUR or SET_MIN; top level muxes alarm time to the display.
- edit_field  out  2  00 none, 01 hour, 10 minute.
- armed  out  1  high in ARMED, RINGING or SNOOZE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; alarm_hour=DEF_HOUR; alarm_min=DEF_MIN.
  - buzzer=0; show_alarm=0; edit_field=00; armed=0.
  - ring_cnt=0; snooze_cnt=0; match_d=0.
  - Reset in any state, including RINGING, silences the buzzer immediately.
- All outputs are registered and update on the clk rising edge after the causing input; latency is 1 cycle.
- Priority: center_pulse beats up_pulse and down_pulse in the same cycle. up and down together mean no change.
- match = (cur_hour==alarm_hour) && (cur_min==alarm_min) && (cur_sec==0). match_d is match registered. trigger = match && !match_d, so there is one trigger per matching minute.
- States:
  - IDLE: alarm disabled. center -> SET_HOUR. up/down ignored.
  - SET_HOUR: up -> hour+1, 23 wraps to 0. down -> hour-1, 0 wraps to 23. center -> SET_MIN.
  - SET_MIN: up/down change minute mod 60 (59->0, 0->59). center -> ARMED. Triggers are ignored while editing.
  - ARMED: trigger -> RINGING. center -> IDLE (disarm).
  - RINGING:
    - On entry: ring_cnt=0, buzzer=1.
    - Each tick: buzzer toggles and ring_cnt+1. When ring_cnt reaches RING_SECS-1 on a tick -> ARMED, buzzer=0.
    - center -> ARMED (dismiss), buzzer=0.
    - up or down -> SNOOZE, snooze_cnt=SNOOZE_MIN*60, buzzer=0.
  - SNOOZE:
    - Each tick: snooze_cnt-1. A tick when snooze_cnt==1 -> RINGING, with re-entry rules as above.
    - center -> ARMED (cancel snooze).
    - trigger is ignored.
- Edge cases:
  - A tick and a button in the same cycle of RINGING: the button wins, and ring_cnt does not matter after exit.
  - Editing in SET_HOUR/SET_MIN never changes cur_* or the time counters.
- Widths: ring_cnt 8 bits, snooze_cnt 12 bits, no overflow within the parameter ranges.

Test Plan:
- Reset, then three center presses -> states SET_HOUR, SET_MIN, ARMED; alarm stays 06:00; show_alarm high only in the two SET states; armed=1 at the end.
- In SET_HOUR at 23, up -> 0. In SET_MIN at 0, down -> 59. up+down in the same cycle -> no change. center+up -> advance state, value unchanged.
- ARMED at 06:00, cur_* steps 05:59:59 -> 06:00:00 -> RINGING next cycle with buzzer=1. Holding 06:00:00 for many cycles does not retrigger.
- RINGING with RING_SECS=3 -> buzzer 1,0,1 over ticks, then ARMED, buzzer=0 after the 3rd tick.
- RINGING, up press -> SNOOZE, buzzer=0. With SNOOZE_MIN=1, after 60 ticks -> RINGING, buzzer=1. center in SNOOZE -> ARMED.
- rst_n low during RINGING -> buzzer=0 asynchronously, state IDLE, alarm back to DEF_HOUR:DEF_MIN.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm sequencer for the wall clock: edits alarm hour/minute from debounced
// button pulses, arms, detects the alarm minute, rings, snoozes and dismisses.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tick_1hz          one-cycle pulse per second
//   up/down/center    debounced one-cycle button pulses
//   cur_hour/min/sec  running time of day
//   alarm_hour/min    stored alarm time
//   buzzer            buzzer drive
//   show_alarm        high while the alarm time is being edited
//   edit_field        00 none, 01 hour, 10 minute
//   armed             high in ARMED, RINGING or SNOOZE
module alarm_controller #(
   parameter int unsigned DEF_HOUR   = 6,
   parameter int unsigned DEF_MIN    = 0,
   parameter int unsigned RING_SECS  = 60,
   parameter int unsigned SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       up_pulse,
   input  logic       down_pulse,
   input  logic       center_pulse,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_min,
   output logic       buzzer,
   output logic       show_alarm,
   output logic [1:0] edit_field,
   output logic       armed
);

   localparam int unsigned HOUR_W        = 5;
   localparam int unsigned MIN_W         = 6;
   localparam int unsigned RING_W        = 8;
   localparam int unsigned SNOOZE_W      = 12;
   localparam int unsigned SNOOZE_RELOAD = SNOOZE_MIN * 60;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      ARMED    = 3'd3,
      RINGING  = 3'd4,
      SNOOZE   = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic [HOUR_W-1:0]   hour_nxt;
   logic [MIN_W-1:0]    min_nxt;
   logic [RING_W-1:0]   ring_cnt, ring_nxt;
   logic [SNOOZE_W-1:0] snooze_cnt, snooze_nxt;
   logic                buzzer_nxt;
   logic                show_nxt;
   logic [1:0]          field_nxt;
   logic                armed_nxt;
   logic                match, match_d, trigger;
   logic                inc, dec, any_ud;

   // One trigger per matching minute: rising edge of the match condition.
   assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == MIN_W'(0));
   assign trigger = match && !match_d;

   // Simultaneous up and down cancel each other.
   assign inc    = up_pulse & ~down_pulse;
   assign dec    = down_pulse & ~up_pulse;
   assign any_ud = up_pulse | down_pulse;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         alarm_hour <= HOUR_W'(DEF_HOUR);
         alarm_min  <= MIN_W'(DEF_MIN);
         ring_cnt   <= '0;
         snooze_cnt <= '0;
         match_d    <= 1'b0;
         buzzer     <= 1'b0;
         show_alarm <= 1'b0;
         edit_field <= 2'b00;
         armed      <= 1'b0;
      end else begin
         state      <= state_nxt;
         alarm_hour <= hour_nxt;
         alarm_min  <= min_nxt;
         ring_cnt   <= ring_nxt;
         snooze_cnt <= snooze_nxt;
         match_d    <= match;
         buzzer     <= buzzer_nxt;
         show_alarm <= show_nxt;
         edit_field <= field_nxt;
         armed      <= armed_nxt;
      end
   end

   // Next state, edited values, counters and buzzer.
   always_comb begin
      state_nxt  = state;
      hour_nxt   = alarm_hour;
      min_nxt    = alarm_min;
      ring_nxt   = ring_cnt;
      snooze_nxt = snooze_cnt;
      buzzer_nxt = buzzer;

      unique case (state)
         IDLE: begin
            buzzer_nxt = 1'b0;
            if (center_pulse) state_nxt = SET_HOUR;
         end
         SET_HOUR: begin
            if (center_pulse) begin
               state_nxt = SET_MIN;
            end else if (inc) begin
               hour_nxt = (alarm_hour == HOUR_W'(23)) ? '0 : alarm_hour + HOUR_W'(1);
            end else if (dec) begin
               hour_nxt = (alarm_hour == '0) ? HOUR_W'(23) : alarm_hour - HOUR_W'(1);
            end
         end
         SET_MIN: begin
            if (center_pulse) begin
               state_nxt = ARMED;
            end else if (inc) begin
               min_nxt = (alarm_min == MIN_W'(59)) ? '0 : alarm_min + MIN_W'(1);
            end else if (dec) begin
               min_nxt = (alarm_min == '0) ? MIN_W'(59) : alarm_min - MIN_W'(1);
            end
         end
         ARMED: begin
            buzzer_nxt = 1'b0;
            if (center_pulse) begin
               state_nxt = IDLE;
            end else if (trigger) begin
               state_nxt  = RINGING;
               ring_nxt   = '0;
               buzzer_nxt = 1'b1;
            end
         end
         RINGING: begin
            // Buttons take precedence over a same-cycle tick.
            if (center_pulse) begin
               state_nxt  = ARMED;
               buzzer_nxt = 1'b0;
            end else if (any_ud) begin
               state_nxt  = SNOOZE;
               snooze_nxt = SNOOZE_W'(SNOOZE_RELOAD);
               buzzer_nxt = 1'b0;
            end else if (tick_1hz) begin
               if (ring_cnt == RING_W'(RING_SECS - 1)) begin
                  state_nxt  = ARMED;
                  buzzer_nxt = 1'b0;
               end else begin
                  ring_nxt   = ring_cnt + RING_W'(1);
                  buzzer_nxt = ~buzzer;
               end
            end
         end
         SNOOZE: begin
            buzzer_nxt = 1'b0;
            if (center_pulse) begin
               state_nxt = ARMED;
            end else if (tick_1hz) begin
               if (snooze_cnt == SNOOZE_W'(1)) begin
                  state_nxt  = RINGING;
                  ring_nxt   = '0;
                  buzzer_nxt = 1'b1;
               end else begin
                  snooze_nxt = snooze_cnt - SNOOZE_W'(1);
               end
            end
         end
         default: begin
            state_nxt  = IDLE;
            buzzer_nxt = 1'b0;
         end
      endcase

      // Status flags follow the state being entered so they line up with it.
      show_nxt  = (state_nxt == SET_HOUR) || (state_nxt == SET_MIN);
      field_nxt = (state_nxt == SET_HOUR) ? 2'b01 :
                  (state_nxt == SET_MIN)  ? 2'b10 : 2'b00;
      armed_nxt = (state_nxt == ARMED) || (state_nxt == RINGING) || (state_nxt == SNOOZE);
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with RING_SECS=3, SNOOZE_MIN=1.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz, up_pulse, down_pulse, center_pulse;
   logic [4:0] cur_hour;
   logic [5:0] cur_min, cur_sec;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       buzzer, show_alarm, armed;
   logic [1:0] edit_field;

   int n_checks = 0;
   int n_pass   = 0;

   alarm_controller #(
      .DEF_HOUR(6), .DEF_MIN(0), .RING_SECS(3), .SNOOZE_MIN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
      .up_pulse(up_pulse), .down_pulse(down_pulse), .center_pulse(center_pulse),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min), .buzzer(buzzer),
      .show_alarm(show_alarm), .edit_field(edit_field), .armed(armed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Drive one cycle of inputs from a negedge; returns at the next negedge.
   task automatic step(input logic u, input logic d, input logic c, input logic t);
      @(negedge clk);
      up_pulse = u; down_pulse = d; center_pulse = c; tick_1hz = t;
      @(negedge clk);
      up_pulse = 0; down_pulse = 0; center_pulse = 0; tick_1hz = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
   endtask

   // Produce a fresh match edge at hh:mm:00.
   task automatic fire(input int h, input int m);
      set_time((m == 0) ? h - 1 : h, (m == 0) ? 59 : m - 1, 59);
      idle(2);
      set_time(h, m, 0);
      idle(1);
   endtask

   initial begin
      rst_n = 0; tick_1hz = 0; up_pulse = 0; down_pulse = 0; center_pulse = 0;
      set_time(0, 0, 0);
      idle(2);
      check("rst_hour", int'(alarm_hour), 6);
      check("rst_min", int'(alarm_min), 0);
      check("rst_buzzer", int'(buzzer), 0);
      check("rst_show", int'(show_alarm), 0);
      check("rst_field", int'(edit_field), 0);
      check("rst_armed", int'(armed), 0);
      rst_n = 1;
      idle(1);

      // Walk IDLE -> SET_HOUR -> SET_MIN -> ARMED.
      step(0, 0, 1, 0);
      check("sh_show", int'(show_alarm), 1);
      check("sh_field", int'(edit_field), 1);
      step(0, 0, 1, 0);
      check("sm_show", int'(show_alarm), 1);
      check("sm_field", int'(edit_field), 2);
      step(0, 0, 1, 0);
      check("arm_show", int'(show_alarm), 0);
      check("arm_field", int'(edit_field), 0);
      check("arm_armed", int'(armed), 1);
      check("arm_hour", int'(alarm_hour), 6);
      check("arm_min", int'(alarm_min), 0);

      // Disarm, then edit with wraps.
      step(0, 0, 1, 0);
      check("disarm", int'(armed), 0);
      step(1, 0, 0, 0);
      check("idle_up_ignored", int'(alarm_hour), 6);
      step(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
      check("hour_down_wrap", int'(alarm_hour), 23);
      step(1, 0, 0, 0);
      check("hour_up_wrap", int'(alarm_hour), 0);
      step(1, 1, 0, 0);
      check("hour_updown", int'(alarm_hour), 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
      check("hour_back6", int'(alarm_hour), 6);
      step(1, 0, 1, 0);
      check("cu_hour_kept", int'(alarm_hour), 6);
      check("cu_to_min", int'(edit_field), 2);
      step(0, 1, 0, 0);
      check("min_down_wrap", int'(alarm_min), 59);
      step(1, 0, 0, 0);
      check("min_up_wrap", int'(alarm_min), 0);
      step(1, 1, 0, 0);
      check("min_updown", int'(alarm_min), 0);
      step(0, 1, 1, 0);
      check("cd_min_kept", int'(alarm_min), 0);
      check("cd_armed", int'(armed), 1);

      // Match at 06:00:00.
      set_time(5, 59, 59);
      idle(2);
      check("pre_match_buz", int'(buzzer), 0);
      set_time(6, 0, 0);
      idle(1);
      check("ring_buz", int'(buzzer), 1);
      check("ring_armed", int'(armed), 1);
      step(0, 0, 1, 0);
      check("dismiss_buz", int'(buzzer), 0);
      idle(10);
      check("no_retrigger", int'(buzzer), 0);
      check("no_retrig_armed", int'(armed), 1);

      // Auto-dismiss after 3 ticks.
      fire(6, 0);
      check("r3_entry", int'(buzzer), 1);
      step(0, 0, 0, 1);
      check("r3_tick1", int'(buzzer), 0);
      step(0, 0, 0, 1);
      check("r3_tick2", int'(buzzer), 1);
      step(0, 0, 0, 1);
      check("r3_tick3", int'(buzzer), 0);
      step(0, 0, 0, 1);
      check("r3_in_armed", int'(buzzer), 0);
      check("r3_armed", int'(armed), 1);

      // Snooze for 60 ticks.
      fire(6, 0);
      step(1, 0, 0, 0);
      check("snooze_buz", int'(buzzer), 0);
      check("snooze_armed", int'(armed), 1);
      for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
      check("snooze_59", int'(buzzer), 0);
      step(0, 0, 0, 1);
      check("snooze_60", int'(buzzer), 1);
      // Button beats a same-cycle tick.
      step(0, 1, 0, 1);
      check("snooze_again", int'(buzzer), 0);
      step(0, 0, 1, 0);
      check("snooze_cancel", int'(armed), 1);
      for (int i = 0; i < 60; i++) step(0, 0, 0, 1);
      check("cancel_silent", int'(buzzer), 0);

      // Move alarm to 07:00, ring, then reset mid-ring.
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("edit7_hour", int'(alarm_hour), 7);
      fire(7, 0);
      check("ring7_buz", int'(buzzer), 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("async_buz", int'(buzzer), 0);
      check("async_armed", int'(armed), 0);
      check("async_hour", int'(alarm_hour), 6);
      check("async_min", int'(alarm_min), 0);
      idle(1);
      rst_n = 1;
      step(0, 0, 0, 1);
      check("post_rst_buz", int'(buzzer), 0);
      check("post_rst_show", int'(show_alarm), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
